clk_out_gate: RTL and testbench
===============================

// Module: clk_out_gate
// PURPOSE
//  Output-buffer stage for one MMCM output clock. Behaviourally models the
//  BUFG, BUFH and BUFGCE primitives. Adds a lock sequencer: a LOCKED shift
//  register clocked by the BUFH copy drives the BUFGCE enable.
//  The gated clock therefore starts only after LOCKED has been stable for
//  SEQ_LEN edges, and always starts glitch-free.
//  One instance sits behind each MMCM CLKOUTn (master, SD, TFT, I2S clocks).
// PARAMETERS
//  SEQ_LEN  8  lock-sequencer depth in clk_in1 rising edges; legal values >= 2
// PORTS
//  clk_in1   in   1        raw MMCM output clock; the single clock of the block
//  rst_n     in   1        asynchronous active-low reset
//  locked    in   1        MMCM LOCKED, asynchronous to clk_in1
//  clk_bufg  out  1        ungated global copy of clk_in1 (BUFG model)
//  clk_bufh  out  1        ungated regional copy of clk_in1 (BUFH model)
//  clk_out   out  1        gated clock (BUFGCE model); low when disabled
//  clk_en    out  1        current BUFGCE CE, equal to seq[SEQ_LEN-1]
//  seq       out  SEQ_LEN  lock-sequencer state, for debug
// BEHAVIOUR
//  - clk_bufg and clk_bufh equal clk_in1 with zero delay; reset does not affect them.
//  - Sequencer: on every rising edge of clk_bufh, seq <= {seq[SEQ_LEN-2:0], locked}.
//    seq[0] and seq[1] act as the synchronizer for locked (ASYNC_REG).
//  - clk_en = seq[SEQ_LEN-1].
//  - BUFGCE model:
//    - ce_q is a latch, transparent while clk_in1 is low and holding while it is high.
//    - clk_out = clk_in1 & ce_q.
//    - Every high pulse on clk_out is full width; no runt pulses and no glitches.
//  - Enable latency: locked rises before edge 1, then seq[SEQ_LEN-1]=1 after edge SEQ_LEN.
//    The first clk_out rising edge is edge SEQ_LEN+1. With the default, that is edge 9.
//  - Lock loss: locked falls before edge k, then clk_en=0 after edge k+SEQ_LEN-1.
//    The last clk_out pulse is the one starting at edge k+SEQ_LEN-1. The output then stays low.
//  - A locked glitch shorter than one clk_in1 period that no edge samples has no effect.
//  - A sampled 0 bubble propagates through seq and causes one missing clk_out pulse,
//    SEQ_LEN edges later.
//  - Reset values: rst_n=0 asynchronously clears seq to 0 and ce_q to 0.
//    clk_en and clk_out go low immediately, so the reset may truncate a high pulse.
//    After release, the sequence restarts from zero; full SEQ_LEN latency applies again.
//  - At power-up (before any reset), seq initialises to 0 and ce_q to 0.
//  - Simultaneous locked change and clk edge: the value sampled is either old or new.
//    Latency varies by at most 1 edge.
// STRUCTURE
//  - Package clk_gate_pkg: default SEQ_LEN constant (8) and a function that checks
//    SEQ_LEN >= 2.
//  - Sub-module bufgce_model (I, CE, rst_n -> O) holds the latch and the AND.
//    The top holds the BUFG/BUFH pass-throughs and the sequencer.
//  - No other state exists. The design is synthesizable apart from the latch,
//    which maps to a BUFGCE on the target.
// TESTING
//  - Reset, then locked=1 with clk_in1 at 100 MHz -> clk_out stays low for 8 edges.
//    The first clk_out rise is at edge 9; clk_en rises after edge 8.
//  - Stable lock, then locked=0 before edge k -> clk_en falls after edge k+7.
//    No pulse narrower than 5 ns appears on clk_out.
//  - Assert rst_n=0 while clk_out is high -> clk_out=0, clk_en=0 and seq=0 at once.
//    Release with locked=1 -> 8-edge latency again.
//  - locked pulse high for 3 edges only -> seq shows the 3-bit run.
//    clk_out gives exactly 3 full pulses, starting at edge 9.
//  - Any state and reset -> clk_bufg and clk_bufh track clk_in1 exactly.
//    Run at 100, 12.5 and 6.25 MHz.
//  - SEQ_LEN=4 build -> the first clk_out rise is at edge 5.

Source files
------------

// File: rtl/clk_gate_pkg.sv
// Shared constants for the MMCM output-clock gate; purely elaborative, no latency.
// Holds the default lock-sequencer depth and its legality check; no flow control involved.
package clk_gate_pkg;

  localparam int SEQ_LEN_DEFAULT = 8;

  // Depth 2 is the minimum: seq[0] and seq[1] form the LOCKED synchronizer.
  function automatic bit seq_len_ok(input int n);
    return n >= 2;
  endfunction

endpackage

// File: rtl/bufgce_model.sv
// BUFGCE behavioural model: CE captured while I is low, O = I & captured CE.
// Enable takes effect on the next full I high phase; no backpressure, free-running.
module bufgce_model (
  input  logic I,
  input  logic CE,
  input  logic rst_n,
  output logic O
);

  logic ce_q;

  // Transparent only while I is low, so CE can never change mid-pulse.
  always_latch begin
    if (!rst_n) begin
      ce_q = 1'b0;
    end else if (!I) begin
      ce_q = CE;
    end
  end

  assign O = I & ce_q;

endmodule

// File: rtl/clk_out_gate.sv
// MMCM output-buffer stage: BUFG/BUFH copies plus a LOCKED-sequenced glitch-free gated clock.
// clk_out starts on edge SEQ_LEN+1 after locked is first sampled; no backpressure.
module clk_out_gate
  import clk_gate_pkg::*;
#(
  parameter int SEQ_LEN = SEQ_LEN_DEFAULT
) (
  input  logic               clk_in1,
  input  logic               rst_n,
  input  logic               locked,
  output logic               clk_bufg,
  output logic               clk_bufh,
  output logic               clk_out,
  output logic               clk_en,
  output logic [SEQ_LEN-1:0] seq
);

  localparam bit SEQ_LEN_LEGAL = seq_len_ok(SEQ_LEN);

  generate
    if (!SEQ_LEN_LEGAL) begin : g_bad_seq_len
      $error("clk_out_gate: SEQ_LEN must be at least 2");
    end
  endgenerate

  assign clk_bufg = clk_in1;
  assign clk_bufh = clk_in1;

  // The two lowest stages double as the synchronizer for the asynchronous locked.
  (* ASYNC_REG = "TRUE" *) logic [SEQ_LEN-1:0] seq_q;
  logic [SEQ_LEN-1:0] seq_d;

  always_comb begin
    seq_d = {seq_q[SEQ_LEN-2:0], locked};
  end

  always_ff @(posedge clk_bufh or negedge rst_n) begin
    if (!rst_n) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_d;
    end
  end

  assign seq    = seq_q;
  assign clk_en = seq_q[SEQ_LEN-1];

  bufgce_model u_bufgce (
    .I     (clk_in1),
    .CE    (clk_en),
    .rst_n (rst_n),
    .O     (clk_out)
  );

endmodule

// File: tb/tb_clk_out_gate.sv
`timescale 1ns/1ps
// Directed bench for clk_out_gate: default depth 8 and a depth-4 build share clock, reset and locked.
module tb_clk_out_gate;

  logic       clk_in1;
  logic       rst_n;
  logic       locked;
  logic       clk_bufg, clk_bufh, clk_out, clk_en;
  logic [7:0] seq;
  logic       clk_bufg4, clk_bufh4, clk_out4, clk_en4;
  logic [3:0] seq4;

  realtime half_ns;
  int      n_cmp;
  int      n_err;
  int      pulse_cnt;
  int      cnt0;
  realtime t_rise;

  clk_out_gate u_dut (
    .clk_in1  (clk_in1),
    .rst_n    (rst_n),
    .locked   (locked),
    .clk_bufg (clk_bufg),
    .clk_bufh (clk_bufh),
    .clk_out  (clk_out),
    .clk_en   (clk_en),
    .seq      (seq)
  );

  clk_out_gate #(.SEQ_LEN(4)) u_dut4 (
    .clk_in1  (clk_in1),
    .rst_n    (rst_n),
    .locked   (locked),
    .clk_bufg (clk_bufg4),
    .clk_bufh (clk_bufh4),
    .clk_out  (clk_out4),
    .clk_en   (clk_en4),
    .seq      (seq4)
  );

  initial begin
    clk_in1 = 1'b0;
    half_ns = 5.0;
    forever begin
      #(half_ns);
      clk_in1 = ~clk_in1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive locked ahead of the next rising edge, then sample 1 ns after it.
  task automatic step(input logic lk);
    @(negedge clk_in1);
    locked = lk;
    @(posedge clk_in1);
    #1;
  endtask

  task automatic latency_run();
    for (int e = 1; e <= 9; e++) begin
      step(1'b1);
      chk("lat_en",   clk_en,   e >= 8);
      chk("lat_out",  clk_out,  e >= 9);
      chk("lat_seq",  seq,      ((1 << e) - 1) & 8'hFF);
      chk("lat_en4",  clk_en4,  e >= 4);
      chk("lat_out4", clk_out4, e >= 5);
    end
  endtask

  // Buffer copies must follow the raw clock through every state, reset included.
  always @(clk_in1) begin
    #1;
    chk("bufg",  clk_bufg,  clk_in1);
    chk("bufh",  clk_bufh,  clk_in1);
    chk("bufg4", clk_bufg4, clk_in1);
  end

  always @(posedge clk_out) begin
    t_rise = $realtime;
    if (rst_n === 1'b1) pulse_cnt++;
  end

  // Reset may legitimately truncate a pulse; every other pulse must be full width.
  always @(negedge clk_out) begin
    if (rst_n === 1'b1) chk("pulse_w", ($realtime - t_rise) >= 4.999, 1);
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    pulse_cnt = 0;
    t_rise    = 0.0;
    rst_n     = 1'b0;
    locked    = 1'b0;

    // Reset state, sampled with the clock high.
    repeat (3) step(1'b0);
    chk("rst_seq",  seq,      0);
    chk("rst_en",   clk_en,   0);
    chk("rst_out",  clk_out,  0);
    chk("rst_seq4", seq4,     0);
    chk("rst_out4", clk_out4, 0);
    @(negedge clk_in1);
    rst_n = 1'b1;

    // 100 MHz: first clk_out rise on edge 9 (edge 5 for depth 4).
    latency_run();

    // Reset while clk_out is high clears everything at once.
    chk("pre_rst_out", clk_out, 1);
    rst_n  = 1'b0;
    locked = 1'b0;
    #0.5;
    chk("arst_out",  clk_out,  0);
    chk("arst_en",   clk_en,   0);
    chk("arst_seq",  seq,      0);
    chk("arst_out4", clk_out4, 0);
    chk("arst_seq4", seq4,     0);
    step(1'b1);
    chk("hold_seq", seq, 0);
    chk("hold_out", clk_out, 0);
    rst_n = 1'b1;
    step(1'b0);
    latency_run();

    // 12.5 MHz: locked falls before edge k (j=1); clk_en falls after edge k+7.
    half_ns = 40.0;
    repeat (3) step(1'b1);
    for (int j = 1; j <= 9; j++) begin
      step(1'b0);
      chk("loss_en",   clk_en,   j < 8);
      chk("loss_out",  clk_out,  j <= 8);
      chk("loss_seq",  seq,      (8'hFF << j) & 8'hFF);
      chk("loss_en4",  clk_en4,  j < 4);
      chk("loss_out4", clk_out4, j <= 4);
    end
    repeat (3) step(1'b0);
    chk("loss_off", clk_out, 0);

    // 6.25 MHz: a short locked glitch between edges is never sampled.
    half_ns = 80.0;
    step(1'b0);
    cnt0 = pulse_cnt;
    @(negedge clk_in1);
    #10;
    locked = 1'b1;
    #2;
    locked = 1'b0;
    repeat (10) step(1'b0);
    chk("glitch_seq",  seq,  0);
    chk("glitch_seq4", seq4, 0);
    chk("glitch_cnt",  pulse_cnt - cnt0, 0);

    // Single sampled 0 bubble removes exactly one pulse, SEQ_LEN edges later.
    repeat (9) step(1'b1);
    chk("bub_pre_out", clk_out, 1);
    for (int e = 1; e <= 11; e++) begin
      step(e != 1);
      chk("bub_en",   clk_en,   e != 8);
      chk("bub_out",  clk_out,  e != 9);
      chk("bub_en4",  clk_en4,  e != 4);
      chk("bub_out4", clk_out4, e != 5);
    end

    // locked high for exactly 3 sampled edges -> 3 full pulses starting at edge 9.
    repeat (9) step(1'b0);
    chk("flush_out", clk_out, 0);
    cnt0 = pulse_cnt;
    for (int e = 1; e <= 13; e++) begin
      step(e <= 3);
      chk("run3_out",  clk_out,  (e >= 9) && (e <= 11));
      chk("run3_out4", clk_out4, (e >= 5) && (e <= 7));
      if (e == 3) chk("run3_seq_e3", seq, 8'h07);
      if (e == 5) chk("run3_seq_e5", seq, 8'h1C);
      if (e == 3) chk("run3_seq4_e3", seq4, 4'h7);
    end
    chk("run3_cnt", pulse_cnt - cnt0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
